// File: rtl/tail_input_conditioner.sv
// tail_input_conditioner: synchronize/debounce turn switches, pace steps with tick, tick-aligned requests
// Define TAIL_HAZARD_EN to add a debounced hazard channel that forces both requests high.

module tail_debounce #(
    parameter int DB_COUNT = 50000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic raw,
    output logic st
);
    localparam int DW = $clog2(DB_COUNT + 1);
    logic [1:0]    sync;
    logic [DW-1:0] dc;
    logic          diff;
    assign diff = sync[1] != st;
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync <= '0;
            dc   <= '0;
            st   <= 1'b0;
        end else begin
            sync <= {sync[0], raw};
            if (diff && dc == DW'(DB_COUNT - 1)) begin
                st <= sync[1];
                dc <= '0;
            end else begin
                dc <= diff ? dc + DW'(1) : '0;
            end
        end
    end
endmodule

module tail_input_conditioner #(
    parameter int DB_COUNT = 50000,
    parameter int TICK_DIV = 12500000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic left_raw,
    input  logic right_raw,
    input  logic hazard_raw,
    output logic left,
    output logic right,
    output logic tick,
    output logic left_db,
    output logic right_db
);
    localparam int PW = $clog2(TICK_DIV);
    logic          st_left, st_right, st_hazard;
    logic [PW-1:0] pc;

    tail_debounce #(.DB_COUNT(DB_COUNT)) u_left (
        .clk(clk), .reset_n(reset_n), .raw(left_raw), .st(st_left)
    );
    tail_debounce #(.DB_COUNT(DB_COUNT)) u_right (
        .clk(clk), .reset_n(reset_n), .raw(right_raw), .st(st_right)
    );
`ifdef TAIL_HAZARD_EN
    tail_debounce #(.DB_COUNT(DB_COUNT)) u_hazard (
        .clk(clk), .reset_n(reset_n), .raw(hazard_raw), .st(st_hazard)
    );
`else
    logic unused_hazard;
    assign unused_hazard = hazard_raw;
    assign st_hazard     = 1'b0;
`endif

    assign tick     = pc == PW'(TICK_DIV - 1);
    assign left_db  = st_left;
    assign right_db = st_right;

    // Requests only move on tick so the FSM sees levels stable across each step.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc    <= '0;
            left  <= 1'b0;
            right <= 1'b0;
        end else begin
            pc <= tick ? '0 : pc + PW'(1);
            if (tick) begin
                left  <= st_left | st_hazard;
                right <= st_right | st_hazard;
            end
        end
    end
endmodule

// File: tb/tb_tail_input_conditioner.sv
// tb_tail_input_conditioner: directed vector table plus bounce, hazard and reset sequences
// Honors TAIL_HAZARD_EN to choose hazard expectations.

module tb_tail_input_conditioner;
`ifdef TAIL_HAZARD_EN
    localparam bit HZ = 1'b1;
`else
    localparam bit HZ = 1'b0;
`endif
    logic clk = 1'b0, reset_n = 1'b0;
    logic left_raw = 1'b0, right_raw = 1'b0, hazard_raw = 1'b0;
    logic left, right, tick, left_db, right_db;
    int checks = 0, errors = 0;

    typedef struct {
        logic       l, r, h;
        int         n;
        logic [4:0] exp;
    } vec_t;
    vec_t vecs[19];

    tail_input_conditioner #(.DB_COUNT(4), .TICK_DIV(8)) dut (
        .clk(clk), .reset_n(reset_n), .left_raw(left_raw), .right_raw(right_raw),
        .hazard_raw(hazard_raw), .left(left), .right(right), .tick(tick),
        .left_db(left_db), .right_db(right_db)
    );

    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [4:0] act, input logic [4:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got {l,r,tick,ldb,rdb}=%b expected %b", name, act, exp);
        end
    endtask

    function automatic logic [4:0] outs();
        return {left, right, tick, left_db, right_db};
    endfunction

    initial begin
        // fields: left_raw, right_raw, hazard_raw, cycles, {left,right,tick,left_db,right_db}
        vecs = '{
            '{1,0,0,5,5'b00000}, '{1,0,0,1,5'b00010}, '{1,0,0,1,5'b00110}, '{1,0,0,1,5'b10010},
            '{0,0,0,5,5'b10010}, '{0,0,0,1,5'b10000}, '{0,0,0,1,5'b10100}, '{0,0,0,1,5'b00000},
            '{0,0,0,2,5'b00000}, '{0,1,0,5,5'b00100}, '{0,1,0,1,5'b00001}, '{0,1,0,7,5'b00101},
            '{0,1,0,1,5'b01001}, '{0,0,0,6,5'b01000}, '{0,0,0,2,5'b00000}, '{1,1,0,6,5'b00011},
            '{1,1,0,2,5'b11011}, '{0,0,0,6,5'b11000}, '{0,0,0,2,5'b00000}
        };
        repeat (3) @(posedge clk);
        #1;
        chk("reset_state", outs(), 5'b00000);
        reset_n = 1'b1;
        for (int i = 0; i < 19; i++) begin
            left_raw   = vecs[i].l;
            right_raw  = vecs[i].r;
            hazard_raw = vecs[i].h;
            step(vecs[i].n);
            chk($sformatf("vec%0d", i), outs(), vecs[i].exp);
        end
        for (int i = 0; i < 10; i++) begin
            left_raw = (i % 2 == 0);
            step(2);
            chk($sformatf("bounce%0d", i), {left, left_db}, 2'b00);
        end
        left_raw = 1'b0;
        step(8);
        chk("bounce_end", outs(), 5'b00000);
        hazard_raw = 1'b1;
        step(6);
        chk("hazard_db", outs(), 5'b00000);
        step(6);
        chk("hazard_tick", outs(), {HZ, HZ, 3'b000});
        hazard_raw = 1'b0;
        step(8);
        chk("hazard_release", outs(), 5'b00000);
        left_raw = 1'b1;
        step(8);
        chk("pre_reset_left", outs(), 5'b10010);
        step(3);
        reset_n = 1'b0;
        #1;
        chk("async_reset", outs(), 5'b00000);
        left_raw = 1'b0;
        step(3);
        chk("held_reset", outs(), 5'b00000);
        reset_n = 1'b1;
        for (int k = 1; k <= 24; k++) begin
            step(1);
            chk($sformatf("tick_e%0d", k), {4'b0000, tick}, {4'b0000, (k % 8 == 7)});
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/tail_input_conditioner.md
# tail_input_conditioner

Input-conditioning stage that sits directly upstream of the tail-light sequencing FSM. It synchronizes and debounces the raw turn-signal switches, generates the slow step-enable tick that paces the light sequence, and presents `left`/`right` request levels that change only on tick boundaries. The FSM's `Left`/`Right` inputs connect to `left`/`right`, and `tick` drives its step enable.

## Interface
- `DB_COUNT`, default 50000: consecutive cycles a synchronized input must differ from its debounced value before that value flips; legal ≥ 1.
- `TICK_DIV`, default 12500000: tick period in `clk` cycles; legal ≥ 2.
- `clk` in 1: single system clock; all state on rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `left_raw` in 1: raw left switch; asynchronous, may bounce.
- `right_raw` in 1: raw right switch; asynchronous, may bounce.
- `hazard_raw` in 1: raw hazard switch; used only with `HAZARD_EN`.
- `left` out 1: registered left request to the FSM.
- `right` out 1: registered right request to the FSM.
- `tick` out 1: one-cycle step-enable pulse.
- `left_db` out 1: debounced left level, for status/debug.
- `right_db` out 1: debounced right level, for status/debug.

## Operation
- **Synchronizer:** two flops per raw input; both reset to 0.
- **Debounce (per channel):** stable bit `st` plus counter `dc` of width `$clog2(DB_COUNT+1)`.
  - If sync ≠ `st` and `dc == DB_COUNT-1`: `st <= sync`, `dc <= 0`.
  - Else if sync ≠ `st`: `dc <= dc+1`.
  - Else: `dc <= 0`. Any single-cycle agreement restarts the count; a bounce never flips `st`.
- **Prescaler:** counter `pc` of width `$clog2(TICK_DIV)` counts 0..`TICK_DIV-1` and wraps to 0. `tick` = (`pc == TICK_DIV-1`), decoded combinationally from the register.
- **Request sampling:** on a cycle with `tick` high, `left <= st_left | st_hazard` and `right <= st_right | st_hazard`. Otherwise `left`/`right` hold.
- `left_db`/`right_db` are the `st` bits directly and update independently of `tick`.
- Both sides requested → both outputs high. Priority resolution belongs to the FSM.

## Timing
- **Reset values:** `left`, `right`, `tick`, `left_db`, `right_db` = 0; every counter and flop = 0.
- **Reset mid-operation:** everything clears immediately, asynchronously. After `reset_n` rises, the first `tick` occurs on the cycle following the `TICK_DIV-1`th rising edge; tick period is exactly `TICK_DIV` cycles.
- **Raw to debounced latency:** a clean level change reaches `st` `2 + DB_COUNT` edges after the first edge that samples it.
- **Debounced to output:** `left`/`right` update at the end of the next `tick` cycle. If `st` flips on the same edge that ends a tick cycle, the old `st` is sampled; the new value appears one tick later.
- **Wrap-around:** `pc` wraps with no dead cycle. `tick` is never high for 2 consecutive cycles, since `TICK_DIV` ≥ 2.

## Configuration
- **`TAIL_HAZARD_EN` defined:** `hazard_raw` gets its own synchronizer and debounce channel identical to left/right. A debounced hazard forces both `left` and `right` high at the next tick.
- **`TAIL_HAZARD_EN` undefined:** the hazard channel is not generated, `hazard_raw` is ignored, and `st_hazard` is a constant 0. The port list is unchanged.

## Test plan
All scenarios use `DB_COUNT=4`, `TICK_DIV=8`.
- **Reset:** assert `reset_n=0` mid-count with `left=1` → all outputs 0 immediately. After release, first `tick` at cycle 7, then every 8 cycles.
- **Clean press:** `left_raw` 0→1 held → `left_db` rises 6 edges later; `left` rises at the end of the next tick cycle; `right` stays 0.
- **Bounce:** `left_raw` toggles every 2 cycles for 20 cycles, then returns to 0 → `left_db` and `left` never leave 0.
- **Tick coincidence:** time `right_raw` so `st_right` flips on the edge ending a tick cycle → `right` stays 0 for that tick and goes 1 exactly 8 cycles later.
- **Both pressed:** `left_raw=right_raw=1` → `left=right=1` from the same tick. Release both → both 0 at the tick following debounce.
- **Hazard, `TAIL_HAZARD_EN` defined:** `hazard_raw=1` alone → `left=right=1` at the next tick after debounce. Undefined → both outputs stay 0.
